// File: rtl/pixel_alu_stream.sv
// Two-stage valid/ready pixel ALU: invert, contrast, threshold, brightness, passthrough.
// Keeps a saturating count of output pixels that had at least one clamped channel.
module pixel_alu_stream #(
  parameter int unsigned CH_W       = 4,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned GAIN_RST   = 6,
  parameter int unsigned THRESH_RST = 6,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned PIX_W     = CH_W * NUM_CH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic [2:0]         in_func,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pixel,
  output logic               out_last,
  input  logic               cfg_load,
  input  logic [3:0]         cfg_gain,
  input  logic [CH_W-1:0]    cfg_thresh,
  input  logic [CH_W:0]      cfg_bright,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   sat_cnt
);

  localparam int unsigned IW = CH_W + 6;
  localparam logic signed [IW-1:0] MID  = IW'(2 ** (CH_W - 1));
  localparam logic signed [IW-1:0] MAXV = IW'(2 ** CH_W - 1);

  typedef enum logic [2:0] {
    OP_INV = 3'b000,
    OP_CON = 3'b001,
    OP_THR = 3'b010,
    OP_BRI = 3'b011
  } op_e;

  generate
    if (CH_W < 2 || CH_W > 8) begin : g_bad_ch_w
      $error("pixel_alu_stream: CH_W must be in 2..8");
    end
  endgenerate

  function automatic logic [CH_W-1:0] clamp(input logic signed [IW-1:0] x);
    if (x < 0)          return '0;
    else if (x > MAXV)  return '1;
    else                return x[CH_W-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [IW-1:0] x);
    return (x < 0) || (x > MAXV);
  endfunction

  // Active configuration
  logic [3:0]             gain;
  logic [CH_W-1:0]        thresh;
  logic signed [CH_W:0]   bright;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain   <= 4'(GAIN_RST);
      thresh <= CH_W'(THRESH_RST);
      bright <= '0;
    end else if (cfg_load) begin
      gain   <= cfg_gain;
      thresh <= cfg_thresh;
      bright <= cfg_bright;
    end
  end

  // Handshake
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Contrast and brightness use the config at accept time, so both are
  // evaluated before the S1 register; only thresh has to travel with the pixel.
  logic signed [IW-1:0] gain_s;
  logic signed [IW-1:0] bright_s;
  logic signed [IW-1:0] con_c [NUM_CH];
  logic signed [IW-1:0] bri_c [NUM_CH];

  assign gain_s   = $signed({{(IW-4){1'b0}}, gain});
  assign bright_s = $signed({{(IW-CH_W-1){bright[CH_W]}}, bright});

  always_comb begin
    logic signed [IW-1:0] vs;
    vs    = '0;
    con_c = '{default: '0};
    bri_c = '{default: '0};
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      vs       = $signed({{(IW-CH_W){1'b0}}, in_pixel[c*CH_W +: CH_W]});
      con_c[c] = (((vs - MID) * gain_s) >>> 2) + MID;
      bri_c[c] = vs + bright_s;
    end
  end

  // Stage 1
  logic [PIX_W-1:0]     s1_pixel;
  logic [2:0]           s1_func;
  logic                 s1_last;
  logic [CH_W-1:0]      s1_thresh;
  logic signed [IW-1:0] s1_con [NUM_CH];
  logic signed [IW-1:0] s1_bri [NUM_CH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      s1_pixel  <= in_pixel;
      s1_func   <= in_func;
      s1_last   <= in_last;
      s1_thresh <= thresh;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        s1_con[c] <= con_c[c];
        s1_bri[c] <= bri_c[c];
      end
    end
  end

  // Stage 2 result selection and clamping
  logic [PIX_W-1:0] s2_pix_c;
  logic             s2_sat_c;

  always_comb begin
    logic [CH_W-1:0] v;
    v        = '0;
    s2_pix_c = '0;
    s2_sat_c = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      v = s1_pixel[c*CH_W +: CH_W];
      case (s1_func)
        OP_INV: s2_pix_c[c*CH_W +: CH_W] = ~v;
        OP_CON: begin
          s2_pix_c[c*CH_W +: CH_W] = clamp(s1_con[c]);
          s2_sat_c |= out_of_range(s1_con[c]);
        end
        OP_THR: s2_pix_c[c*CH_W +: CH_W] = (v > s1_thresh) ? '1 : '0;
        OP_BRI: begin
          s2_pix_c[c*CH_W +: CH_W] = clamp(s1_bri[c]);
          s2_sat_c |= out_of_range(s1_bri[c]);
        end
        default: s2_pix_c[c*CH_W +: CH_W] = v;
      endcase
    end
  end

  logic s2_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
      s2_sat    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pixel <= s2_pix_c;
        out_last  <= s1_last;
        s2_sat    <= s2_sat_c;
      end
    end
  end

  // Saturation event counter; clear wins over a coincident increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && s2_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_alu_stream.sv
// Scoreboard bench for pixel_alu_stream: stimulus pushes model results, a monitor pops and compares.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_pixel_alu_stream;

  localparam int CH_W   = 4;
  localparam int NUM_CH = 3;
  localparam int PIX_W  = CH_W * NUM_CH;
  localparam int M      = 2 ** CH_W - 1;
  localparam int MID    = 2 ** (CH_W - 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               in_valid;
  logic               in_ready, in_ready_s;
  logic [PIX_W-1:0]   in_pixel;
  logic [2:0]         in_func;
  logic               in_last;
  logic               out_valid, out_valid_s;
  logic               out_ready;
  logic [PIX_W-1:0]   out_pixel, out_pixel_s;
  logic               out_last, out_last_s;
  logic               cfg_load;
  logic [3:0]         cfg_gain;
  logic [CH_W-1:0]    cfg_thresh;
  logic [CH_W:0]      cfg_bright;
  logic               cnt_clr;
  logic [15:0]        sat_cnt;
  logic [1:0]         sat_cnt_s;

  pixel_alu_stream #(.CH_W(CH_W), .NUM_CH(NUM_CH), .GAIN_RST(6), .THRESH_RST(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_func(in_func), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_last(out_last), .cfg_load(cfg_load), .cfg_gain(cfg_gain),
    .cfg_thresh(cfg_thresh), .cfg_bright(cfg_bright), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt));

  pixel_alu_stream #(.CH_W(CH_W), .NUM_CH(NUM_CH), .GAIN_RST(6), .THRESH_RST(6), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_pixel(in_pixel),
    .in_func(in_func), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_pixel(out_pixel_s), .out_last(out_last_s), .cfg_load(cfg_load), .cfg_gain(cfg_gain),
    .cfg_thresh(cfg_thresh), .cfg_bright(cfg_bright), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt_s));

  typedef struct {
    logic [PIX_W-1:0] pix;
    bit               last;
    bit               sat;
    int               acc;
    bit               lat;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  int    rdy_mode = 0;
  int    m_gain = 6, m_thr = 6, m_bri = 0;
  int    m_cnt = 0, m_cnt_s = 0;
  bit    lit_en = 1'b0;
  logic [PIX_W-1:0] lit_pix;
  bit    lit_sat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: per-channel integer arithmetic straight from the operation rules
  function automatic void model(input logic [PIX_W-1:0] p, input logic [2:0] f, input int g,
                                input int th, input int br, output logic [PIX_W-1:0] r,
                                output bit sat);
    int v, t, x;
    r = '0;
    sat = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      v = int'(p[c*CH_W +: CH_W]);
      case (f)
        3'd0: x = M - v;
        3'd1: begin
          t = (v - MID) * g;
          x = ((t >= 0) ? t / 4 : -((3 - t) / 4)) + MID;
        end
        3'd2: x = (v > th) ? M : 0;
        3'd3: x = v + br;
        default: x = v;
      endcase
      if (x < 0 || x > M) begin
        if (f == 3'd1 || f == 3'd3) sat = 1'b1;
        x = (x < 0) ? 0 : M;
      end
      r[c*CH_W +: CH_W] = x[CH_W-1:0];
    end
  endfunction

  task automatic tick(output bit acc);
    item_t it;
    logic [PIX_W-1:0] r;
    bit s;
    @(negedge clk);
    #2;
    acc = in_valid && in_ready && rst_n;
    if (acc) begin
      model(in_pixel, in_func, m_gain, m_thr, m_bri, r, s);
      if (lit_en) begin
        r = lit_pix;
        s = lit_sat;
      end
      it.pix = r; it.last = in_last; it.sat = s; it.acc = cyc; it.lat = (rdy_mode == 0);
      q.push_back(it);
    end
    if (!rst_n) begin
      m_gain = 6; m_thr = 6; m_bri = 0;
    end else if (cfg_load) begin
      m_gain = int'(cfg_gain);
      m_thr  = int'(cfg_thresh);
      m_bri  = int'($signed(cfg_bright));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  task automatic send(input logic [PIX_W-1:0] p, input logic [2:0] f, input bit l, output int ticks);
    bit acc;
    in_pixel = p; in_func = f; in_last = l; in_valid = 1'b1;
    ticks = 0;
    acc = 1'b0;
    while (!acc && ticks < 300) begin
      tick(acc);
      ticks++;
    end
    in_valid = 1'b0;
    lit_en = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pixel 0x%0h not accepted within %0d cycles", p, ticks);
    end
  endtask

  task automatic send_lit(input logic [PIX_W-1:0] p, input logic [2:0] f, input bit l,
                          input logic [PIX_W-1:0] exp, input bit exp_sat);
    int t;
    lit_en = 1'b1; lit_pix = exp; lit_sat = exp_sat;
    send(p, f, l, t);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_pixel"}, 32'(out_pixel), 32'(0));
    chk({tag, "_out_last"},  32'(out_last),  32'(0));
    chk({tag, "_sat_cnt"},   32'(sat_cnt),   32'(0));
    chk({tag, "_in_ready"},  32'(in_ready),  32'(1));
  endtask

  // Monitor
  bit               prev_stall = 1'b0;
  logic [PIX_W-1:0] prev_pix;
  bit               prev_last;

  always @(negedge clk) begin
    item_t it;
    bit fire, inc;
    if (mon_en) begin
      chk("sat_cnt", 32'(sat_cnt), 32'(m_cnt));
      chk("sat_cnt_narrow", 32'(sat_cnt_s), 32'(m_cnt_s));
      chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      chk("in_ready_narrow", 32'(in_ready_s), 32'(!(q.size() == 2 && !out_ready)));
      if (prev_stall) begin
        chk("stall_valid_hold", 32'(out_valid), 32'(1));
        chk("stall_pixel_hold", 32'(out_pixel), 32'(prev_pix));
        chk("stall_last_hold",  32'(out_last),  32'(prev_last));
      end
      inc = 1'b0;
      if (!rst_n) begin
        q.delete();
        m_cnt = 0;
        m_cnt_s = 0;
      end else begin
        fire = out_valid && out_ready;
        if (out_valid && q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: pixel 0x%0h with nothing outstanding (t=%0t)", out_pixel, $time);
        end else if (fire) begin
          it = q.pop_front();
          chk("out_pixel", 32'(out_pixel), 32'(it.pix));
          chk("out_last",  32'(out_last),  32'(it.last));
          chk("out_valid_narrow", 32'(out_valid_s), 32'(1));
          chk("out_pixel_narrow", 32'(out_pixel_s), 32'(it.pix));
          chk("out_last_narrow",  32'(out_last_s),  32'(it.last));
          if (it.lat) chk("latency", 32'(cyc - it.acc), 32'(2));
          inc = it.sat;
        end
        if (cnt_clr) begin
          m_cnt = 0;
          m_cnt_s = 0;
        end else if (inc) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_s < 3) m_cnt_s++;
        end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_pix   = out_pixel;
      prev_last  = out_last;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; in_func = '0; in_last = 1'b0;
    cfg_load = 1'b0; cfg_gain = 4'd6; cfg_thresh = 4'd6; cfg_bright = '0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset("reset");
    mon_en = 1'b1;

    // Invert, then an 8-beat back-to-back burst
    send_lit(12'h1A5, 3'b000, 1'b0, 12'hE5A, 1'b0);
    for (int i = 1; i < 8; i++) begin
      send(PIX_W'($urandom), 3'($urandom_range(0, 7)), (i == 7), t);
      chk("burst_accept_cycles", 32'(t), 32'(1));
    end
    idle(4);

    // Contrast at reset gain 1.5x
    send_lit(12'hFA0, 3'b001, 1'b0, 12'hFB0, 1'b1);
    send_lit(12'h888, 3'b001, 1'b1, 12'h888, 1'b0);
    idle(4);

    // Threshold; config loaded together with pixel A applies only from pixel B
    send_lit(12'h769, 3'b010, 1'b0, 12'hF0F, 1'b0);
    cfg_thresh = 4'd8;
    cfg_load = 1'b1;
    send_lit(12'h769, 3'b010, 1'b0, 12'hF0F, 1'b0);
    cfg_load = 1'b0;
    send_lit(12'h769, 3'b010, 1'b1, 12'h00F, 1'b0);
    idle(4);

    // Brightness +3 then -2
    cfg_bright = 5'd3;
    cfg_load = 1'b1;
    idle(1);
    cfg_load = 1'b0;
    send_lit(12'hE10, 3'b011, 1'b0, 12'hF43, 1'b1);
    cfg_bright = 5'b11110;
    cfg_load = 1'b1;
    idle(1);
    cfg_load = 1'b0;
    send_lit(12'h1F3, 3'b011, 1'b1, 12'h0D1, 1'b1);
    idle(4);

    // Clear in the same cycle a clamped pixel leaves
    send_lit(12'hFA0, 3'b001, 1'b0, 12'hFB0, 1'b1);
    idle(1);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    chk("clr_coincident", 32'(sat_cnt), 32'(0));
    idle(3);

    // Reset with two pixels in flight
    rdy_mode = 2;
    idle(2);
    send(PIX_W'($urandom), 3'b001, 1'b0, t);
    send(PIX_W'($urandom), 3'b011, 1'b1, t);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check_reset("midreset");
    rdy_mode = 0;
    idle(6);

    // Random traffic under random backpressure
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_gain   = 4'($urandom_range(0, 15));
        cfg_thresh = 4'($urandom_range(0, 15));
        cfg_bright = 5'($urandom_range(0, 31));
        cfg_load   = 1'b1;
      end
      send(PIX_W'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), t);
      cfg_load = 1'b0;
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    rdy_mode = 0;
    for (int i = 0; i < 100 && q.size() != 0; i++) idle(1);
    chk("drain_empty", 32'(q.size()), 32'(0));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
